// File: rtl/axi_lite_master.sv
// AXI4-Lite initiator: one outstanding single-word read or write per command,
// with a saturating per-transaction latency count returned with the response.
module axi_lite_master #(
   parameter int DW = 32,
   parameter int CW = 16
) (
   input  logic            ACLK,
   input  logic            ARESET,
   input  logic            cmd_valid,
   output logic            cmd_ready,
   input  logic            cmd_write,
   input  logic [31:0]     cmd_addr,
   input  logic [DW-1:0]   cmd_wdata,
   input  logic [DW/8-1:0] cmd_wstrb,
   output logic            rsp_valid,
   input  logic            rsp_ready,
   output logic            rsp_write,
   output logic [DW-1:0]   rsp_rdata,
   output logic [1:0]      rsp_resp,
   output logic [CW-1:0]   rsp_cycles,
   output logic [31:0]     M_AXIL_AWADDR,
   output logic            M_AXIL_AWVALID,
   input  logic            M_AXIL_AWREADY,
   output logic [DW-1:0]   M_AXIL_WDATA,
   output logic [DW/8-1:0] M_AXIL_WSTRB,
   output logic            M_AXIL_WVALID,
   input  logic            M_AXIL_WREADY,
   input  logic [1:0]      M_AXIL_BRESP,
   input  logic            M_AXIL_BVALID,
   output logic            M_AXIL_BREADY,
   output logic [31:0]     M_AXIL_ARADDR,
   output logic            M_AXIL_ARVALID,
   input  logic            M_AXIL_ARREADY,
   input  logic [DW-1:0]   M_AXIL_RDATA,
   input  logic [1:0]      M_AXIL_RRESP,
   input  logic            M_AXIL_RVALID,
   output logic            M_AXIL_RREADY
);

   localparam int SW = DW / 8;

   typedef enum logic [2:0] {
      IDLE,
      WREQ,
      WRESP,
      RREQ,
      RRESP,
      DONE
   } state_t;

   state_t state_q, state_d;

   logic [31:0]   addr_q;
   logic [DW-1:0] wdata_q;
   logic [SW-1:0] wstrb_q;
   logic          write_q;
   logic          aw_done_q, w_done_q;
   logic [CW-1:0] cnt_q;
   logic [DW-1:0] rdata_q;
   logic [1:0]    resp_q;

   logic cmd_hs, aw_hs, w_hs, b_hs, ar_hs, r_hs, busy;

   // Handshakes derived from state so VALIDs never loop back through READY
   assign cmd_hs = cmd_valid & (state_q == IDLE) & ~ARESET;
   assign aw_hs  = (state_q == WREQ) & ~aw_done_q & M_AXIL_AWREADY;
   assign w_hs   = (state_q == WREQ) & ~w_done_q & M_AXIL_WREADY;
   assign b_hs   = (state_q == WRESP) & M_AXIL_BVALID;
   assign ar_hs  = (state_q == RREQ) & M_AXIL_ARREADY;
   assign r_hs   = (state_q == RRESP) & M_AXIL_RVALID;
   assign busy   = (state_q == WREQ) | (state_q == WRESP) |
                   (state_q == RREQ) | (state_q == RRESP);

   always_ff @(posedge ACLK) begin
      if (ARESET) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d        = state_q;
      cmd_ready      = 1'b0;
      rsp_valid      = 1'b0;
      M_AXIL_AWVALID = 1'b0;
      M_AXIL_WVALID  = 1'b0;
      M_AXIL_BREADY  = 1'b0;
      M_AXIL_ARVALID = 1'b0;
      M_AXIL_RREADY  = 1'b0;
      unique case (state_q)
         IDLE: begin
            cmd_ready = ~ARESET;
            if (cmd_hs) state_d = cmd_write ? WREQ : RREQ;
         end
         WREQ: begin
            M_AXIL_AWVALID = ~aw_done_q;
            M_AXIL_WVALID  = ~w_done_q;
            if ((aw_done_q | aw_hs) & (w_done_q | w_hs)) state_d = WRESP;
         end
         WRESP: begin
            M_AXIL_BREADY = 1'b1;
            if (b_hs) state_d = DONE;
         end
         RREQ: begin
            M_AXIL_ARVALID = 1'b1;
            if (ar_hs) state_d = RRESP;
         end
         RRESP: begin
            M_AXIL_RREADY = 1'b1;
            if (r_hs) state_d = DONE;
         end
         DONE: begin
            rsp_valid = 1'b1;
            if (rsp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         addr_q    <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         write_q   <= 1'b0;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
         cnt_q     <= '0;
         rdata_q   <= '0;
         resp_q    <= '0;
      end else begin
         if (cmd_hs) begin
            addr_q    <= cmd_addr;
            wdata_q   <= cmd_wdata;
            wstrb_q   <= cmd_wstrb;
            write_q   <= cmd_write;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            cnt_q     <= '0;
         end
         if (aw_hs) aw_done_q <= 1'b1;
         if (w_hs)  w_done_q  <= 1'b1;
         if (busy && cnt_q != '1)
            cnt_q <= cnt_q + {{(CW-1){1'b0}}, 1'b1};
         if (b_hs) begin
            resp_q  <= M_AXIL_BRESP;
            rdata_q <= '0;
         end
         if (r_hs) begin
            resp_q  <= M_AXIL_RRESP;
            rdata_q <= M_AXIL_RDATA;
         end
      end
   end

   assign M_AXIL_AWADDR = addr_q;
   assign M_AXIL_ARADDR = addr_q;
   assign M_AXIL_WDATA  = wdata_q;
   assign M_AXIL_WSTRB  = wstrb_q;
   assign rsp_write     = write_q;
   assign rsp_rdata     = rdata_q;
   assign rsp_resp      = resp_q;
   assign rsp_cycles    = cnt_q;

endmodule

// File: tb/tb_axi_lite_master.sv
// Bench for axi_lite_master: delay-parameterised slave, event-time reference
// model for every output over each transaction, plus reset scenarios.
module tb_axi_lite_master;

   localparam int DW  = 32;
   localparam int CW  = 4;
   localparam int SW  = DW / 8;
   localparam int SAT = (1 << CW) - 1;

   logic            ACLK = 1'b0;
   logic            ARESET;
   logic            cmd_valid, cmd_ready, cmd_write;
   logic [31:0]     cmd_addr;
   logic [DW-1:0]   cmd_wdata;
   logic [SW-1:0]   cmd_wstrb;
   logic            rsp_valid, rsp_ready, rsp_write;
   logic [DW-1:0]   rsp_rdata;
   logic [1:0]      rsp_resp;
   logic [CW-1:0]   rsp_cycles;
   logic [31:0]     AWADDR, ARADDR;
   logic            AWVALID, AWREADY, WVALID, WREADY;
   logic [DW-1:0]   WDATA, RDATA;
   logic [SW-1:0]   WSTRB;
   logic [1:0]      BRESP, RRESP;
   logic            BVALID, BREADY, ARVALID, ARREADY, RVALID, RREADY;

   int checks = 0;
   int errors = 0;

   always #5 ACLK = ~ACLK;

   axi_lite_master #(.DW(DW), .CW(CW)) dut (
      .ACLK(ACLK), .ARESET(ARESET),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_write(cmd_write), .cmd_addr(cmd_addr),
      .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_write(rsp_write), .rsp_rdata(rsp_rdata),
      .rsp_resp(rsp_resp), .rsp_cycles(rsp_cycles),
      .M_AXIL_AWADDR(AWADDR), .M_AXIL_AWVALID(AWVALID),
      .M_AXIL_AWREADY(AWREADY),
      .M_AXIL_WDATA(WDATA), .M_AXIL_WSTRB(WSTRB),
      .M_AXIL_WVALID(WVALID), .M_AXIL_WREADY(WREADY),
      .M_AXIL_BRESP(BRESP), .M_AXIL_BVALID(BVALID),
      .M_AXIL_BREADY(BREADY),
      .M_AXIL_ARADDR(ARADDR), .M_AXIL_ARVALID(ARVALID),
      .M_AXIL_ARREADY(ARREADY),
      .M_AXIL_RDATA(RDATA), .M_AXIL_RRESP(RRESP),
      .M_AXIL_RVALID(RVALID), .M_AXIL_RREADY(RREADY)
   );

   task automatic idle_inputs();
      cmd_valid = 0; cmd_write = 0; cmd_addr = '0;
      cmd_wdata = '0; cmd_wstrb = '0; rsp_ready = 0;
      AWREADY = 0; WREADY = 0; BVALID = 0; BRESP = '0;
      ARREADY = 0; RVALID = 0; RDATA = '0; RRESP = '0;
   endtask

   task automatic test_reset();
      idle_inputs();
      ARESET = 1;
      cmd_valid = 1;
      repeat (2) @(posedge ACLK);
      @(negedge ACLK);
      checks++;
      if (cmd_ready !== 1'b0) begin
         errors++;
         $display("FAIL reset_cmd_ready got %b want 0", cmd_ready);
      end
      checks++;
      if ({AWVALID, WVALID, ARVALID, BREADY, RREADY, rsp_valid} !== 6'b0) begin
         errors++;
         $display("FAIL reset_outputs got %b want 000000",
                  {AWVALID, WVALID, ARVALID, BREADY, RREADY, rsp_valid});
      end
      cmd_valid = 0;
      ARESET = 0;
      @(posedge ACLK);
      @(negedge ACLK);
      checks++;
      if ({cmd_ready, rsp_valid} !== 2'b10) begin
         errors++;
         $display("FAIL reset_release got ready/valid %b want 10",
                  {cmd_ready, rsp_valid});
      end
      checks++;
      if ({rsp_cycles, rsp_resp, rsp_rdata} !== '0) begin
         errors++;
         $display("FAIL reset_rsp_regs got cyc %0d resp %0d rdata %h want 0",
                  rsp_cycles, rsp_resp, rsp_rdata);
      end
   endtask

   // Runs one command against a slave whose READY/VALID delays are given.
   // Expected output timeline follows from the edge-time arithmetic below.
   task automatic run_txn(input bit wr, input logic [31:0] addr,
                          input logic [DW-1:0] data,
                          input logic [SW-1:0] strb,
                          input logic [1:0] resp, input int cmd_d,
                          input int aw_d, input int w_d, input int b_d,
                          input int ar_d, input int r_d, input int rr_d,
                          input string name);
      int k, awh, wh, e, arh, dh, rh, exp_cyc;
      int aw_seen, w_seen, b_wait, ar_seen, r_wait, rr_wait;
      int aw_edge, w_edge, ar_edge, hs_edge, bad, first_bad, unstable;
      bit cmd_taken, aw_ok, w_ok, b_ok, ar_ok, r_ok, seen_rsp;
      logic [DW+CW+2:0] first_fields, hs_fields;
      logic [DW-1:0] exp_rdata;
      logic [6:0] x;

      k = cmd_d;
      awh = k + 1 + aw_d;
      wh = k + 1 + w_d;
      e = (awh > wh) ? awh : wh;
      arh = k + 1 + ar_d;
      dh = wr ? e + 1 + b_d : arh + 1 + r_d;
      rh = dh + 1 + rr_d;
      exp_cyc = (dh - k > SAT) ? SAT : dh - k;
      exp_rdata = wr ? '0 : data;

      aw_seen = 0; w_seen = 0; b_wait = 0;
      ar_seen = 0; r_wait = 0; rr_wait = 0;
      aw_edge = -1; w_edge = -1; ar_edge = -1; hs_edge = -1;
      bad = 0; first_bad = -1; unstable = 0;
      cmd_taken = 0; aw_ok = 0; w_ok = 0; b_ok = 0;
      ar_ok = 0; r_ok = 0; seen_rsp = 0;
      first_fields = '0; hs_fields = '0;

      cmd_write = wr; cmd_addr = addr;
      cmd_wdata = wr ? data : ~data;
      cmd_wstrb = strb;

      for (int n = 0; n <= rh + 30; n++) begin
         if (n > 0) begin
            int t;
            t = n - 1;
            x[6] = (t < k) || (t >= rh);
            x[5] = wr && t >= k && t < awh;
            x[4] = wr && t >= k && t < wh;
            x[3] = wr && t >= e && t < dh;
            x[2] = !wr && t >= k && t < arh;
            x[1] = !wr && t >= arh && t < dh;
            x[0] = t >= dh && t < rh;
            if ({cmd_ready, AWVALID, WVALID, BREADY,
                 ARVALID, RREADY, rsp_valid} !== x) begin
               bad++;
               if (first_bad < 0) first_bad = t;
            end
            if (AWVALID === 1'b1 && AWADDR !== addr) bad++;
            if (WVALID === 1'b1 && {WDATA, WSTRB} !== {data, strb}) bad++;
            if (ARVALID === 1'b1 && ARADDR !== addr) bad++;
            if (hs_edge >= 0 && t >= hs_edge) break;
         end

         cmd_valid = (n >= cmd_d) && !cmd_taken;
         if (cmd_valid && cmd_ready === 1'b1) cmd_taken = 1;

         AWREADY = 0;
         if (AWVALID === 1'b1 && !aw_ok) begin
            AWREADY = aw_seen >= aw_d;
            aw_seen++;
            if (AWREADY) begin aw_ok = 1; aw_edge = n; end
         end
         WREADY = 0;
         if (WVALID === 1'b1 && !w_ok) begin
            WREADY = w_seen >= w_d;
            w_seen++;
            if (WREADY) begin w_ok = 1; w_edge = n; end
         end
         BVALID = 0;
         BRESP = ~resp;
         if (aw_ok && w_ok && !b_ok && n > aw_edge && n > w_edge) begin
            BVALID = b_wait >= b_d;
            b_wait++;
            if (BVALID) BRESP = resp;
            if (BVALID && BREADY === 1'b1) b_ok = 1;
         end
         ARREADY = 0;
         if (ARVALID === 1'b1 && !ar_ok) begin
            ARREADY = ar_seen >= ar_d;
            ar_seen++;
            if (ARREADY) begin ar_ok = 1; ar_edge = n; end
         end
         RVALID = 0;
         RRESP = ~resp;
         RDATA = ~data;
         if (ar_ok && !r_ok && n > ar_edge) begin
            RVALID = r_wait >= r_d;
            r_wait++;
            if (RVALID) begin RRESP = resp; RDATA = data; end
            if (RVALID && RREADY === 1'b1) r_ok = 1;
         end
         rsp_ready = 0;
         if (rsp_valid === 1'b1 && hs_edge < 0) begin
            if (!seen_rsp)
               first_fields = {rsp_write, rsp_rdata, rsp_resp, rsp_cycles};
            else if ({rsp_write, rsp_rdata, rsp_resp, rsp_cycles} !== first_fields)
               unstable++;
            seen_rsp = 1;
            rsp_ready = rr_wait >= rr_d;
            rr_wait++;
            if (rsp_ready) begin
               hs_edge = n;
               hs_fields = {rsp_write, rsp_rdata, rsp_resp, rsp_cycles};
            end
         end
         @(posedge ACLK);
         @(negedge ACLK);
      end
      idle_inputs();

      checks++;
      if (hs_edge != rh) begin
         errors++;
         $display("FAIL %s rsp_handshake_edge got %0d want %0d", name, hs_edge, rh);
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL %s timeline got %0d bad samples (first t=%0d) want 0",
                  name, bad, first_bad);
      end
      checks++;
      if (unstable != 0) begin
         errors++;
         $display("FAIL %s rsp_stable got %0d changes want 0", name, unstable);
      end
      checks++;
      if (hs_fields[DW+CW+2] !== wr) begin
         errors++;
         $display("FAIL %s rsp_write got %b want %b", name, hs_fields[DW+CW+2], wr);
      end
      checks++;
      if (hs_fields[DW+CW+1:CW+2] !== exp_rdata) begin
         errors++;
         $display("FAIL %s rsp_rdata got %h want %h", name,
                  hs_fields[DW+CW+1:CW+2], exp_rdata);
      end
      checks++;
      if (hs_fields[CW+1:CW] !== resp) begin
         errors++;
         $display("FAIL %s rsp_resp got %0d want %0d", name, hs_fields[CW+1:CW], resp);
      end
      checks++;
      if (int'(hs_fields[CW-1:0]) != exp_cyc) begin
         errors++;
         $display("FAIL %s rsp_cycles got %0d want %0d", name,
                  hs_fields[CW-1:0], exp_cyc);
      end
      if (hs_edge < 0) begin
         ARESET = 1;
         @(posedge ACLK);
         @(negedge ACLK);
         ARESET = 0;
      end
   endtask

   task automatic test_zero_wait_write();
      run_txn(1, 32'h04, 32'hDEADBEEF, 4'hF, 2'b00, 0, 0, 0, 0, 0, 0, 0, "zero_wait_write");
   endtask

   task automatic test_skewed_write();
      run_txn(1, 32'h08, 32'hCAFEF00D, 4'h3, 2'b00, 0, 0, 3, 0, 0, 0, 0, "skewed_write");
   endtask

   task automatic test_read();
      run_txn(0, 32'h40, 32'h11111111, 4'h0, 2'b00, 0, 0, 0, 0, 1, 0, 0, "read");
   endtask

   task automatic test_slverr();
      run_txn(1, 32'h10, 32'h12345678, 4'hF, 2'b10, 0, 1, 0, 1, 0, 0, 0, "slverr");
   endtask

   task automatic test_backpressure();
      run_txn(0, 32'h20, 32'hA5A55A5A, 4'h0, 2'b01, 0, 0, 0, 0, 0, 2, 5, "backpressure");
   endtask

   task automatic test_saturation();
      run_txn(1, 32'h30, 32'h0BADC0DE, 4'h9, 2'b00, 0, 16, 2, 1, 0, 0, 0, "saturation");
   endtask

   task automatic test_back_to_back();
      run_txn(1, 32'h50, 32'h01020304, 4'hF, 2'b00, 0, 0, 0, 0, 0, 0, 0, "b2b_0");
      run_txn(0, 32'h54, 32'h05060708, 4'h0, 2'b00, 0, 0, 0, 0, 0, 0, 0, "b2b_1");
      run_txn(1, 32'h58, 32'h090A0B0C, 4'h1, 2'b11, 0, 0, 0, 0, 0, 0, 0, "b2b_2");
   endtask

   task automatic test_random();
      for (int i = 0; i < 12; i++) begin
         run_txn(1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFC, $urandom,
                 SW'($urandom), 2'($urandom_range(0, 3)), $urandom_range(0, 2),
                 $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                 $sformatf("random_%0d", i));
      end
   endtask

   task automatic test_mid_reset();
      bit reached;
      reached = 0;
      idle_inputs();
      cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h60;
      cmd_wdata = 32'h55AA55AA; cmd_wstrb = 4'hF;
      AWREADY = 1; WREADY = 1;
      @(posedge ACLK);
      @(negedge ACLK);
      cmd_valid = 0;
      for (int i = 0; i < 10; i++) begin
         if (BREADY === 1'b1) begin reached = 1; break; end
         @(posedge ACLK);
         @(negedge ACLK);
      end
      checks++;
      if (!reached) begin
         errors++;
         $display("FAIL mid_reset_reach_wresp got BREADY %b want 1", BREADY);
      end
      ARESET = 1;
      @(posedge ACLK);
      #1;
      checks++;
      if ({cmd_ready, AWVALID, WVALID, BREADY, ARVALID, RREADY, rsp_valid} !== 7'b0) begin
         errors++;
         $display("FAIL mid_reset_outputs got %b want 0000000",
                  {cmd_ready, AWVALID, WVALID, BREADY, ARVALID, RREADY, rsp_valid});
      end
      @(negedge ACLK);
      ARESET = 0;
      AWREADY = 0; WREADY = 0;
      @(posedge ACLK);
      @(negedge ACLK);
      checks++;
      if ({cmd_ready, rsp_valid} !== 2'b10) begin
         errors++;
         $display("FAIL mid_reset_release got ready/valid %b want 10",
                  {cmd_ready, rsp_valid});
      end
      checks++;
      if (rsp_cycles !== '0) begin
         errors++;
         $display("FAIL mid_reset_counter got %0d want 0", rsp_cycles);
      end
   endtask

   initial begin
      ARESET = 1;
      idle_inputs();
      test_reset();
      test_zero_wait_write();
      test_skewed_write();
      test_read();
      test_slverr();
      test_backpressure();
      test_saturation();
      test_back_to_back();
      test_random();
      test_mid_reset();
      test_zero_wait_write();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
